emif_req_issuer: RTL and testbench
==================================

EMIF_REQ_ISSUER -- requirements
Module: emif_req_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of accepted-request buffer entries (power of 2, >=2).
REQ-002 Parameter MAX_OUTSTANDING, default 16: maximum EMIF reads issued without readdatavalid returned.
REQ-003 Clocking is fixed: one clock, clk; reset is reset_n, asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_request  input  mem_request_t  granted request from the upstream round-robin arbiter; valid when read|write.
REQ-007 out_port_ready  output  1  back-pressure to the arbiter; a request transfers on a rising edge where (read|write) && out_port_ready.
REQ-008 avm_address  output  27  EMIF word address.
REQ-009 avm_read / avm_write  output  1 each  EMIF command strobes, mutually exclusive.
REQ-010 avm_waitrequest  input  1  EMIF stall; command held unchanged while high.
REQ-011 avm_readdatavalid  input  1  one pulse per completed read.
REQ-012 outstanding_rd  output  $clog2(MAX_OUTSTANDING+1)  current in-flight read count.

Function
REQ-013 Accepted requests enter a FIFO_DEPTH-entry in-order buffer; out_port_ready SHALL equal (entry count < FIFO_DEPTH) && reset_n, decoded from registered state only (no combinational path from in_request or avm_* inputs).
REQ-014 A request with both read and write set SHALL be accepted and issued as a read; write is dropped.
REQ-015 Accept and pop in the same cycle with buffer full: accept is blocked (ready low); with buffer non-full, count stays unchanged.
REQ-016 FSM states IDLE, ISSUE, THROTTLE; IDLE->ISSUE when buffer non-empty and (head is write or outstanding_rd < MAX_OUTSTANDING); IDLE->THROTTLE when head is read and outstanding_rd == MAX_OUTSTANDING.
REQ-017 ISSUE: avm_read/avm_write/avm_address registered from buffer head; on cycle with !avm_waitrequest the head pops; next state ISSUE if a further eligible entry exists (back-to-back, no bubble), THROTTLE if next head is a read at limit, else IDLE.
REQ-018 THROTTLE: strobes low; ->ISSUE the cycle after outstanding_rd drops below MAX_OUTSTANDING.
REQ-019 Minimum latency: request accepted at edge N SHALL present its strobe on avm_* after edge N+1.
REQ-020 While avm_waitrequest is high, avm_address and strobes SHALL remain stable.
REQ-021 outstanding_rd increments on (avm_read && !avm_waitrequest), decrements on avm_readdatavalid, unchanged when both occur; readdatavalid at zero SHALL be ignored (saturate at 0, no wrap).
REQ-022 Requests issue to EMIF strictly in acceptance order.

Reset
REQ-023 reset_n low SHALL immediately clear: buffer empty, FSM IDLE, avm_read=0, avm_write=0, avm_address=0, outstanding_rd=0, out_port_ready=0.
REQ-024 Reset asserted mid-command or with reads outstanding SHALL discard all state; no strobes until a new request is accepted after reset release.
REQ-025 First accept is possible on the first rising edge after reset_n deasserts.

Structure
REQ-026 mem_request_t and the 27-bit address width come from the shared ctrl_signal_types package; the FSM state enum is added there as issuer_state_t.
REQ-027 The in-order buffer SHALL be a sub-module req_sync_fifo (parameterised by depth and mem_request_t), with full/empty/count outputs.

Verification
REQ-028 Single read 0x8, waitrequest=0 -> avm_read=1, avm_address=0x8 for exactly one cycle, one edge after accept; outstanding_rd 0->1; readdatavalid pulse -> 0.
REQ-029 Five writes 0xA..0xE back-to-back, waitrequest=0 -> ready drops after 4 buffered if EMIF slow; with EMIF free, writes issue on consecutive cycles in order.
REQ-030 Write 0xA4 with waitrequest high 3 cycles -> avm_write/address 0xA4 held 4 cycles, popped once.
REQ-031 MAX_OUTSTANDING=2, three reads 0x10,0x11,0x12, no readdatavalid -> third stays in THROTTLE; one readdatavalid -> 0x12 issues next cycle.
REQ-032 Simultaneous read issue and readdatavalid at outstanding_rd=1 -> stays 1; readdatavalid at 0 -> stays 0.
REQ-033 reset_n pulsed low during held write with 2 reads outstanding -> all outputs zero immediately; no stale command after release.

Source files
------------

// File: rtl/ctrl_signal_types.sv
// Shared controller types: arbiter request bundle and EMIF issuer state.
package ctrl_signal_types;

    localparam int EMIF_ADDR_W = 27;

    typedef struct packed {
        logic                   read;
        logic                   write;
        logic [EMIF_ADDR_W-1:0] address;
    } mem_request_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_THROTTLE
    } issuer_state_t;

    // A request carrying both strobes is a read; the write is dropped.
    function automatic mem_request_t as_cmd(mem_request_t r);
        mem_request_t c;
        c       = r;
        c.write = r.write & ~r.read;
        return c;
    endfunction

endpackage

// File: rtl/req_sync_fifo.sv
// In-order request buffer with head and next-after-head lookahead.
module req_sync_fifo
    import ctrl_signal_types::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mem_request_t
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output T                           next_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_q + AW'(1)];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/emif_req_issuer.sv
// Buffers arbiter requests and issues them in order to the EMIF Avalon port.
module emif_req_issuer
    import ctrl_signal_types::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  mem_request_t                           in_request,
    output logic                                   out_port_ready,
    output logic [EMIF_ADDR_W-1:0]                 avm_address,
    output logic                                   avm_read,
    output logic                                   avm_write,
    input  logic                                   avm_waitrequest,
    input  logic                                   avm_readdatavalid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_rd
);

    localparam int             OW   = $clog2(MAX_OUTSTANDING+1);
    localparam int             CW   = $clog2(FIFO_DEPTH+1);
    localparam logic [OW-1:0]  OMAX = OW'(MAX_OUTSTANDING);

    issuer_state_t  state_q, state_d;
    mem_request_t   cmd_q, cmd_d;
    logic [OW-1:0]  out_q, out_d;

    mem_request_t   head, nxt;
    logic [CW-1:0]  count;
    logic           full, empty;
    logic           push, pop;
    logic           issue_rd, retire_rd;

    assign out_port_ready = !full && reset_n;
    assign push           = (in_request.read || in_request.write) && out_port_ready;

    req_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mem_request_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (in_request),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (nxt),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign avm_read       = cmd_q.read;
    assign avm_write      = cmd_q.write;
    assign avm_address    = cmd_q.address;
    assign outstanding_rd = out_q;

    assign issue_rd  = cmd_q.read && !avm_waitrequest;
    assign retire_rd = avm_readdatavalid && (out_q != '0);

    always_comb begin
        out_d = out_q;
        unique case ({issue_rd, retire_rd})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (head.read && out_q == OMAX) begin
                        state_d = ST_THROTTLE;
                    end else begin
                        state_d = ST_ISSUE;
                        cmd_d   = as_cmd(head);
                    end
                end
            end
            ST_ISSUE: begin
                if (!avm_waitrequest) begin
                    pop         = 1'b1;
                    cmd_d.read  = 1'b0;
                    cmd_d.write = 1'b0;
                    state_d     = ST_IDLE;
                    // Look past the popping head so back-to-back has no bubble.
                    if (count >= CW'(2)) begin
                        if (nxt.read && out_d == OMAX) begin
                            state_d = ST_THROTTLE;
                        end else begin
                            state_d = ST_ISSUE;
                            cmd_d   = as_cmd(nxt);
                        end
                    end
                end
            end
            ST_THROTTLE: begin
                if (out_q < OMAX) begin
                    state_d = ST_ISSUE;
                    cmd_d   = as_cmd(head);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_emif_req_issuer.sv
// Directed bench with an in-order issue scoreboard and read-credit model.
module tb_emif_req_issuer;
    import ctrl_signal_types::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    mem_request_t           in_request = '0;
    logic                   out_port_ready;
    logic [EMIF_ADDR_W-1:0] avm_address;
    logic                   avm_read;
    logic                   avm_write;
    logic                   avm_waitrequest = 1'b0;
    logic                   avm_readdatavalid = 1'b0;
    logic [1:0]             outstanding_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit                     rd;
        logic [EMIF_ADDR_W-1:0] a;
    } exp_t;

    exp_t                   q[$];
    int                     mout = 0;
    bit                     hold_v = 0;
    logic                   p_rd, p_wr;
    logic [EMIF_ADDR_W-1:0] p_addr;

    emif_req_issuer #(
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_request        (in_request),
        .out_port_ready    (out_port_ready),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .outstanding_rd    (outstanding_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Model: accepted-but-not-issued queue and read credits from handshakes.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            mout   = 0;
            hold_v = 0;
            chk("rst_ready", out_port_ready, 0);
            chk("rst_rd", avm_read, 0);
            chk("rst_wr", avm_write, 0);
            chk("rst_addr", avm_address, 0);
            chk("rst_out", outstanding_rd, 0);
        end else begin
            int nm;
            chk("ready", out_port_ready, q.size() < DEPTH);
            chk("outstanding", outstanding_rd, mout);
            chk("strobe_mutex", avm_read && avm_write, 0);
            if (hold_v) begin
                chk("hold_addr", avm_address, p_addr);
                chk("hold_rd", avm_read, p_rd);
                chk("hold_wr", avm_write, p_wr);
            end
            if (avm_read) chk("rd_within_limit", mout < MAXO, 1);
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                chk("issue_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("issue_addr", avm_address, e.a);
                    chk("issue_is_read", avm_read, e.rd);
                end
            end
            nm = mout;
            if (avm_read && !avm_waitrequest) nm++;
            if (avm_readdatavalid && mout > 0) nm--;
            mout = nm;
            if ((in_request.read || in_request.write) && out_port_ready)
                q.push_back('{rd: in_request.read, a: in_request.address});
            hold_v = (avm_read || avm_write) && avm_waitrequest;
            p_rd   = avm_read;
            p_wr   = avm_write;
            p_addr = avm_address;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit r, input bit w, input logic [26:0] a);
        in_request = mem_request_t'{read: r, write: w, address: a};
        for (int n = 0; n < 50 && !out_port_ready; n++) tick();
        chk("accept_ready", out_port_ready, 1);
        tick();
        in_request = '0;
    endtask

    task automatic rdv_pulse();
        avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("t_rst_ready", out_port_ready, 0);
        chk("t_rst_rd", avm_read, 0);
        reset_n = 1'b1;
        #1;
        chk("t_ready_after_rst", out_port_ready, 1);
        tick();

        // single read
        send(1, 0, 27'h8);
        chk("r028_not_yet", avm_read, 0);
        tick();
        chk("r028_rd", avm_read, 1);
        chk("r028_addr", avm_address, 27'h8);
        chk("r028_out0", outstanding_rd, 0);
        tick();
        chk("r028_one_cycle", avm_read, 0);
        chk("r028_out1", outstanding_rd, 1);
        rdv_pulse();
        chk("r028_out_back", outstanding_rd, 0);

        // five writes, EMIF free: one per cycle
        for (int i = 0; i < 6; i++) begin
            if (i < 5) in_request = mem_request_t'{read: 1'b0, write: 1'b1,
                                                  address: 27'(32'hA + i)};
            else       in_request = '0;
            tick();
            if (i >= 1) begin
                chk("r029_wr", avm_write, 1);
                chk("r029_addr", avm_address, 27'(32'hA + i - 1));
            end
        end
        in_request = '0;
        tick();
        chk("r029_done", avm_write, 0);

        // five writes, EMIF stalled: ready drops after four
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 1, 27'(32'hA + i));
        chk("r029_full", out_port_ready, 0);
        in_request = mem_request_t'{read: 1'b0, write: 1'b1, address: 27'hE};
        tick();
        chk("r029_still_full", out_port_ready, 0);
        avm_waitrequest = 1'b0;
        send(0, 1, 27'hE);
        repeat (8) tick();
        chk("r029_drained", avm_write, 0);

        // write held by waitrequest for three cycles
        avm_waitrequest = 1'b1;
        send(0, 1, 27'hA4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("r030_wr", avm_write, 1);
            chk("r030_addr", avm_address, 27'hA4);
            if (i == 3) avm_waitrequest = 1'b0;
            tick();
        end
        chk("r030_released", avm_write, 0);

        // throttle at the read limit
        send(1, 0, 27'h10);
        send(1, 0, 27'h11);
        send(1, 0, 27'h12);
        repeat (4) tick();
        chk("r031_throttled", avm_read, 0);
        chk("r031_out2", outstanding_rd, 2);
        rdv_pulse();
        chk("r031_wait", avm_read, 0);
        chk("r031_out1", outstanding_rd, 1);
        tick();
        chk("r031_rd", avm_read, 1);
        chk("r031_addr", avm_address, 27'h12);
        tick();
        chk("r031_out_full", outstanding_rd, 2);

        // simultaneous issue and retire, then saturation at zero
        rdv_pulse();
        send(1, 0, 27'h20);
        tick();
        chk("r032_rd", avm_read, 1);
        chk("r032_out_pre", outstanding_rd, 1);
        avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        chk("r032_simul", outstanding_rd, 1);
        rdv_pulse();
        chk("r032_zero", outstanding_rd, 0);
        rdv_pulse();
        chk("r032_sat", outstanding_rd, 0);

        // read+write request issues as read
        send(1, 1, 27'h60);
        tick();
        chk("r014_rd", avm_read, 1);
        chk("r014_wr", avm_write, 0);
        chk("r014_addr", avm_address, 27'h60);
        tick();
        rdv_pulse();

        // reset during a held write with two reads outstanding
        send(1, 0, 27'h30);
        send(1, 0, 27'h31);
        repeat (3) tick();
        chk("r033_out2", outstanding_rd, 2);
        avm_waitrequest = 1'b1;
        send(0, 1, 27'h40);
        tick();
        chk("r033_wr_held", avm_write, 1);
        reset_n = 1'b0;
        #1;
        chk("r033_rd0", avm_read, 0);
        chk("r033_wr0", avm_write, 0);
        chk("r033_addr0", avm_address, 0);
        chk("r033_out0", outstanding_rd, 0);
        chk("r033_ready0", out_port_ready, 0);
        tick();
        tick();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r033_no_stale_wr", avm_write, 0);
            chk("r033_no_stale_rd", avm_read, 0);
        end
        send(1, 0, 27'h50);
        tick();
        chk("r033_new_rd", avm_read, 1);
        chk("r033_new_addr", avm_address, 27'h50);
        chk("r033_new_out", outstanding_rd, 0);
        tick();
        rdv_pulse();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
